seq_mul_shift_add: RTL and testbench



---
 rtl/seq_mul_defs_pkg.sv | 18 +
 rtl/mul_addsub_unit.sv | 36 +++
 rtl/seq_mul_shift_add.sv | 144 ++++++++++++++
 tb/tb_seq_mul_shift_add.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_defs_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_defs
// Shared definitions for the sequential shift-and-add multiplier:
//   - FSM state encoding (binary): S_IDLE, S_CALC, S_DONE
//   - default operand width and iteration-counter width
// -----------------------------------------------------------------------------
package seq_mul_defs;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : seq_mul_defs

// File: rtl/mul_addsub_unit.sv
// -----------------------------------------------------------------------------
// mul_addsub_unit
// N-bit ripple-carry adder/subtractor built from full-adder cells.
//   sum/carry = x + (sub ? ~y : y) + sub
// Ports:
//   x     in  N  first operand
//   y     in  N  second operand
//   sub   in  1  1 = subtract (invert y and inject carry-in)
//   sum   out N  result
//   carry out 1  carry out of the most significant cell
// -----------------------------------------------------------------------------
module mul_addsub_unit #(
  parameter int N = 5
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         carry
);

  logic [N-1:0] y_eff;
  logic         cy;

  always_comb begin
    y_eff = y ^ {N{sub}};
    cy    = sub;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = x[i] ^ y_eff[i] ^ cy;
      cy     = (x[i] & y_eff[i]) | (cy & (x[i] ^ y_eff[i]));
    end
    carry = cy;
  end

endmodule : mul_addsub_unit

// File: rtl/seq_mul_shift_add.sv
// -----------------------------------------------------------------------------
// seq_mul_shift_add
// Sequential shift-and-add multiplier. Operands are latched on a start
// request taken in IDLE; WIDTH iterations follow (one adder pass per cycle),
// then a one-cycle done strobe. product holds until the next completion.
//
// Optional build macro: SEQ_MUL_SIGNED_EN
//   defined   -> two's-complement operands (sign-extended accumulate,
//                final iteration subtracts the multiplicand)
//   undefined -> unsigned operands
//
// Ports:
//   clk     in  1        system clock, rising edge
//   rst_n   in  1        asynchronous active-low reset
//   start   in  1        request; only sampled in IDLE
//   a       in  WIDTH    multiplicand
//   b       in  WIDTH    multiplier
//   busy    out 1        high while iterating
//   done    out 1        one-cycle completion strobe
//   product out 2*WIDTH  result register
// -----------------------------------------------------------------------------
module seq_mul_shift_add
  import seq_mul_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  state_t            state, state_next;
  logic [WIDTH-1:0]  m_reg;   // latched multiplicand
  logic [WIDTH-1:0]  q_reg;   // multiplier, shifted right; low product bits enter at the top
  logic [WIDTH-1:0]  p_reg;   // accumulator (high half of the running product)
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH:0]    adder_x;
  logic [WIDTH:0]    adder_y;
  logic              adder_sub;
  logic [WIDTH:0]    adder_sum;
  logic              add_carry_unused;

  logic              last_iter;
  logic [WIDTH-1:0]  p_next;
  logic [WIDTH-1:0]  q_next;

  assign last_iter = (cnt == CNT_W'(1));

  // Adder operand selection. When Q[0]=0 the adder passes P through.
`ifdef SEQ_MUL_SIGNED_EN
  always_comb begin
    adder_x   = {p_reg[WIDTH-1], p_reg};
    adder_y   = q_reg[0] ? {m_reg[WIDTH-1], m_reg} : '0;
    // The multiplier's sign bit has negative weight, so the last partial
    // product is subtracted rather than added.
    adder_sub = q_reg[0] & last_iter;
  end
`else
  always_comb begin
    adder_x   = {1'b0, p_reg};
    adder_y   = q_reg[0] ? {1'b0, m_reg} : '0;
    adder_sub = 1'b0;
  end
`endif

  mul_addsub_unit #(
    .N (WIDTH + 1)
  ) u_addsub (
    .x     (adder_x),
    .y     (adder_y),
    .sub   (adder_sub),
    .sum   (adder_sum),
    .carry (add_carry_unused)
  );

  // {P,Q} <= {sum, Q[WIDTH-1:1]}: the WIDTH+1-bit sum already carries the
  // carry (unsigned) or the sign (signed) in its top bit.
  assign p_next = adder_sum[WIDTH:1];
  assign q_next = {adder_sum[0], q_reg[WIDTH-1:1]};

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last_iter) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      q_reg   <= '0;
      p_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= a;
            q_reg <= b;
            p_reg <= '0;
            cnt   <= CNT_W'(WIDTH);
          end
        end
        S_CALC: begin
          p_reg <= p_next;
          q_reg <= q_next;
          cnt   <= cnt - CNT_W'(1);
          if (last_iter) product <= {p_next, q_next};
        end
        default: ;
      endcase
    end
  end

endmodule : seq_mul_shift_add

// File: tb/tb_seq_mul_shift_add.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_shift_add
// Scoreboard bench: the driver pushes the expected product and the start edge
// for each accepted request; the monitor pops on every done strobe and checks
// value and latency, and checks that product holds between completions.
// -----------------------------------------------------------------------------
module tb_seq_mul_shift_add;

  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] prod;
    int             k;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t           exp_q[$];
  int             cyc;
  int             n_pass;
  int             n_total;
  logic [2*W-1:0] held;

  seq_mul_shift_add #(
    .WIDTH (W),
    .CNT_W (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
`ifdef SEQ_MUL_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_total = n_total + 1;
    if (act == req) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done || start) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W-1:0] e);
    exp_t x;
    wait_idle();
    a     = ia;
    b     = ib;
    start = 1'b1;
    x.prod = e;
    x.k    = cyc + 1;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  // Monitor
  initial begin
    exp_t x;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          x = exp_q.pop_front();
          check("product", int'(product), int'(x.prod));
          check("latency", cyc - x.k, W);
          check("busy_at_done", int'(busy), 0);
          held = x.prod;
        end
      end else begin
        check("product_hold", int'(product), int'(held));
      end
    end
  end

  // Driver
  initial begin
    exp_t x;
    int   k;
    int   n;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_product", int'(product), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
`ifdef SEQ_MUL_SIGNED_EN
    issue(4'hD, 4'h5, 8'hF1);
    issue(4'h8, 4'h8, 8'h40);
    issue(4'h7, 4'h8, 8'hC8);
    issue(4'h0, 4'h9, 8'h00);
`else
    issue(4'h3, 4'h5, 8'h0F);
    issue(4'hF, 4'hF, 8'hE1);
    issue(4'h0, 4'h9, 8'h00);
`endif
    repeat (3) @(negedge clk);

    // start held high; a changes during CALC; restart only at edge k+W+2
    wait_idle();
    a     = 4'h2;
    b     = 4'h7;
    start = 1'b1;
    k     = cyc + 1;
    x.prod = ref_mul(4'h2, 4'h7);
    x.k    = k;
    exp_q.push_back(x);
    x.prod = ref_mul(4'h9, 4'h7);
    x.k    = k + W + 2;
    exp_q.push_back(x);
    @(negedge clk);
    a = 4'h9;
    while (cyc < k + W + 2) @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);

    // Asynchronous reset mid-operation
    wait_idle();
    a     = 4'h7;
    b     = 4'h6;
    start = 1'b1;
    k     = cyc + 1;
    x.prod = 8'h2A;
    x.k    = k;
    exp_q.push_back(x);
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    rst_n = 1'b0;
    held  = '0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_product", int'(product), 0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(4'h7, 4'h6, ref_mul(4'h7, 4'h6));

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      issue(ra, rb, ref_mul(ra, rb));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_seq_mul_shift_add
